out_monitor: RTL and testbench

OUT_MONITOR -- requirements
Module: out_monitor

---
 rtl/out_monitor_pkg.sv | 12 +
 rtl/out_monitor_fifo.sv | 87 ++++++++
 rtl/out_monitor.sv | 90 +++++++++
 tb/tb_out_monitor.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_monitor_pkg.sv
// Shared types and default sizes for the CPU output monitor.
package out_monitor_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 16;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

endpackage

// File: rtl/out_monitor_fifo.sv
// Capture FIFO: registered pop data, sticky overflow, push allowed into a full FIFO when popping.
module out_monitor_fifo
    import out_monitor_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     rd_valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     overflow_o,
    output logic                     full_next_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             overflow_q;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_valid_q <= pop_ok;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            if (push_i && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: reset clears the pointers and count, discarding contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign count_o     = count_q;
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CW'(DEPTH));
    assign overflow_o  = overflow_q;
    assign full_next_o = (count_d == CW'(DEPTH));

endmodule

// File: rtl/out_monitor.sv
// CPU output monitor: captures changes of cpu_out into a FIFO and raises haltext on
// a watchpoint match or (optionally) a full FIFO.
module out_monitor
    import out_monitor_pkg::*;
#(
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned DEPTH        = DEF_DEPTH,
    parameter bit          HALT_ON_FULL = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       cpu_out,
    input  logic                   watch_en,
    input  logic [WIDTH-1:0]       watch_val,
    input  logic                   resume,
    input  logic                   rd_en,
    output logic                   haltext,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow
);

    state_e           state_q;
    logic             haltext_q;
    logic             first_q;
    logic [WIDTH-1:0] last_q;
    logic             push;
    logic             full_next;
    logic             halt_cond;

    assign push      = (state_q == RUN) && (first_q || (cpu_out != last_q));
    // Full is judged on the occupancy after this edge's push/pop.
    assign halt_cond = (watch_en && (cpu_out == watch_val)) || (HALT_ON_FULL && full_next);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            haltext_q <= 1'b0;
            first_q   <= 1'b1;
            last_q    <= '0;
        end else begin
            if (push) begin
                last_q  <= cpu_out;
                first_q <= 1'b0;
            end
            case (state_q)
                RUN: begin
                    if (halt_cond) begin
                        state_q   <= HALTED;
                        haltext_q <= 1'b1;
                    end
                end
                HALTED: begin
                    if (resume && !halt_cond) begin
                        state_q   <= RUN;
                        haltext_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= RUN;
                    haltext_q <= 1'b0;
                end
            endcase
        end
    end

    assign haltext = haltext_q;

    out_monitor_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (cpu_out),
        .pop_i       (rd_en),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .count_o     (count),
        .empty_o     (empty),
        .full_o      (full),
        .overflow_o  (overflow),
        .full_next_o (full_next)
    );

endmodule

// File: tb/tb_out_monitor.sv
// Directed table-driven bench for out_monitor, plus hand-written full/reset/halt sequences.
module tb_out_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_out;
    logic        watch_en;
    logic [31:0] watch_val;
    logic        resume;
    logic        rd_en;

    logic        haltext, rd_valid, empty, full, overflow;
    logic [31:0] rd_data;
    logic [4:0]  count;

    logic        haltext2, rd_valid2, empty2, full2, overflow2;
    logic [31:0] rd_data2;
    logic [2:0]  count2;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    out_monitor #(
        .WIDTH        (32),
        .DEPTH        (16),
        .HALT_ON_FULL (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_out   (cpu_out),
        .watch_en  (watch_en),
        .watch_val (watch_val),
        .resume    (resume),
        .rd_en     (rd_en),
        .haltext   (haltext),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow)
    );

    out_monitor #(
        .WIDTH        (32),
        .DEPTH        (4),
        .HALT_ON_FULL (1'b1)
    ) dut_hf (
        .clk       (clk),
        .reset     (reset),
        .cpu_out   (cpu_out),
        .watch_en  (watch_en),
        .watch_val (watch_val),
        .resume    (resume),
        .rd_en     (rd_en),
        .haltext   (haltext2),
        .rd_data   (rd_data2),
        .rd_valid  (rd_valid2),
        .count     (count2),
        .empty     (empty2),
        .full      (full2),
        .overflow  (overflow2)
    );

    typedef struct {
        logic [31:0] cpu;
        logic        we;
        logic [31:0] wv;
        logic        res;
        logic        rd;
        logic        e_halt;
        logic [4:0]  e_cnt;
        logic        e_vld;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        cpu_out   = '0;
        watch_en  = 1'b0;
        watch_val = '0;
        resume    = 1'b0;
        rd_en     = 1'b0;

        //             cpu  we wv  res rd   halt cnt vld data
        tbl[0]  = '{  5, 0,  0, 0, 0,   0,  1,  0,  0};
        tbl[1]  = '{  5, 0,  0, 0, 0,   0,  1,  0,  0};
        tbl[2]  = '{  7, 0,  0, 0, 0,   0,  2,  0,  0};
        tbl[3]  = '{  7, 0,  0, 0, 0,   0,  2,  0,  0};
        tbl[4]  = '{  9, 0,  0, 0, 0,   0,  3,  0,  0};
        tbl[5]  = '{  9, 0,  0, 0, 1,   0,  2,  1,  5};
        tbl[6]  = '{  9, 0,  0, 0, 1,   0,  1,  1,  7};
        tbl[7]  = '{  9, 0,  0, 0, 1,   0,  0,  1,  9};
        tbl[8]  = '{  9, 0,  0, 0, 1,   0,  0,  0,  9};
        tbl[9]  = '{ 11, 1, 12, 0, 0,   0,  1,  0,  9};
        tbl[10] = '{ 12, 1, 12, 0, 0,   1,  2,  0,  9};
        tbl[11] = '{ 13, 1, 12, 0, 0,   1,  2,  0,  9};
        tbl[12] = '{ 12, 1, 12, 1, 0,   1,  2,  0,  9};
        tbl[13] = '{ 12, 0, 12, 1, 0,   0,  2,  0,  9};
        tbl[14] = '{ 12, 0,  0, 0, 0,   0,  2,  0,  9};
        tbl[15] = '{ 14, 0,  0, 1, 0,   0,  3,  0,  9};
        tbl[16] = '{ 14, 0,  0, 0, 1,   0,  2,  1, 11};
        tbl[17] = '{ 14, 0,  0, 0, 1,   0,  1,  1, 12};
        tbl[18] = '{ 14, 0,  0, 0, 1,   0,  0,  1, 14};

        // Asynchronous reset before any clock edge.
        #2 reset = 1'b0;
        #1;
        chk("rst_haltext",  32'(haltext),  0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data",  rd_data,       0);
        chk("rst_count",    32'(count),    0);
        chk("rst_empty",    32'(empty),    1);
        chk("rst_full",     32'(full),     0);
        chk("rst_overflow", 32'(overflow), 0);
        step();
        step();
        reset = 1'b1;

        for (int i = 0; i < 19; i++) begin
            cpu_out   = tbl[i].cpu;
            watch_en  = tbl[i].we;
            watch_val = tbl[i].wv;
            resume    = tbl[i].res;
            rd_en     = tbl[i].rd;
            step();
            chk($sformatf("v%0d_haltext", i),  32'(haltext),  32'(tbl[i].e_halt));
            chk($sformatf("v%0d_count", i),    32'(count),    32'(tbl[i].e_cnt));
            chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].e_vld));
            chk($sformatf("v%0d_rd_data", i),  rd_data,       tbl[i].e_data);
            chk($sformatf("v%0d_empty", i),    32'(empty),    32'(tbl[i].e_cnt == 0));
        end
        resume = 1'b0;
        rd_en  = 1'b0;

        // 17 distinct values into a 16-deep FIFO; watchpoint on the 17th freezes capture.
        do_reset();
        watch_en = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            cpu_out = 32'(i);
            if (i == 17) begin
                watch_en  = 1'b1;
                watch_val = 32'd17;
            end
            step();
        end
        chk("ovf_count",    32'(count),    16);
        chk("ovf_full",     32'(full),     1);
        chk("ovf_overflow", 32'(overflow), 1);
        chk("ovf_haltext",  32'(haltext),  1);
        rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("ovf_pop%0d_data", i), rd_data, 32'(i));
            chk($sformatf("ovf_pop%0d_vld", i),  32'(rd_valid), 1);
        end
        chk("ovf_drained_count", 32'(count), 0);
        chk("ovf_drained_empty", 32'(empty), 1);
        step();
        chk("empty_pop_vld",   32'(rd_valid), 0);
        chk("empty_pop_count", 32'(count),    0);
        chk("empty_pop_data",  rd_data,       16);
        chk("overflow_sticky", 32'(overflow), 1);
        rd_en = 1'b0;

        // Push and pop together on a full FIFO.
        do_reset();
        watch_en = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            cpu_out = 32'(i);
            step();
        end
        chk("pp_full_pre",     32'(full),     1);
        chk("pp_overflow_pre", 32'(overflow), 0);
        cpu_out   = 32'd100;
        rd_en     = 1'b1;
        watch_en  = 1'b1;
        watch_val = 32'd100;
        step();
        chk("pp_count",    32'(count),    16);
        chk("pp_overflow", 32'(overflow), 0);
        chk("pp_rd_data",  rd_data,       1);
        chk("pp_rd_valid", 32'(rd_valid), 1);
        chk("pp_haltext",  32'(haltext),  1);
        for (int i = 2; i <= 17; i++) begin
            step();
            chk($sformatf("pp_pop%0d", i), rd_data, (i <= 16) ? 32'(i) : 32'd100);
        end
        chk("pp_drained", 32'(count), 0);
        rd_en    = 1'b0;
        watch_en = 1'b0;

        // Asynchronous reset mid-cycle while holding four entries and halted.
        do_reset();
        for (int i = 21; i <= 24; i++) begin
            cpu_out = 32'(i);
            step();
        end
        chk("ar_count4", 32'(count), 4);
        cpu_out   = 32'd25;
        rd_en     = 1'b1;
        watch_en  = 1'b1;
        watch_val = 32'd25;
        step();
        chk("ar_pre_haltext", 32'(haltext), 1);
        chk("ar_pre_count",   32'(count),   4);
        chk("ar_pre_rd_data", rd_data,      21);
        rd_en = 1'b0;
        #3 reset = 1'b0;
        #1;
        chk("ar_haltext",  32'(haltext),  0);
        chk("ar_rd_valid", 32'(rd_valid), 0);
        chk("ar_rd_data",  rd_data,       0);
        chk("ar_count",    32'(count),    0);
        chk("ar_empty",    32'(empty),    1);
        chk("ar_full",     32'(full),     0);
        chk("ar_overflow", 32'(overflow), 0);
        watch_en = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("ar_first_count",   32'(count),   1);
        chk("ar_first_haltext", 32'(haltext), 0);
        rd_en = 1'b1;
        step();
        chk("ar_first_data", rd_data, 25);
        rd_en = 1'b0;

        // Halt on full (DEPTH=4 instance).
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cpu_out = 32'(i);
            step();
            if (i == 3) chk("hf_halt_at3", 32'(haltext2), 0);
        end
        chk("hf_halt_at4", 32'(haltext2), 1);
        chk("hf_count4",   32'(count2),   4);
        chk("hf_full",     32'(full2),    1);
        cpu_out = 32'd5;
        step();
        chk("hf_no_push_count", 32'(count2),    4);
        chk("hf_no_overflow",   32'(overflow2), 0);
        resume = 1'b1;
        step();
        chk("hf_resume_full", 32'(haltext2), 1);
        rd_en = 1'b1;
        step();
        chk("hf_resume_pop_halt",  32'(haltext2), 0);
        chk("hf_resume_pop_count", 32'(count2),   3);
        chk("hf_resume_pop_data",  rd_data2,      1);
        rd_en  = 1'b0;
        resume = 1'b0;
        step();
        chk("hf_refill_halt",  32'(haltext2), 1);
        chk("hf_refill_count", 32'(count2),   4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
